// File: rtl/bsg_wait_cycles_driver.sv
// Initiator for a bsg_wait_cycles-style timer: fires activate pulses, waits for
// ready per repetition with a timeout, and returns completion status via valid/yumi.
module bsg_wait_cycles_driver #(
  parameter int unsigned reps_width_p = 8,
  parameter int unsigned timeout_p    = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic [reps_width_p-1:0] reps_i,
  output logic                    ready_and_o,
  output logic                    activate_o,
  input  logic                    ready_r_i,
  output logic                    v_o,
  output logic [reps_width_p-1:0] reps_done_o,
  output logic                    timeout_o,
  input  logic                    yumi_i
);

  localparam int unsigned ctr_width_lp = $clog2(timeout_p + 1);

  typedef enum logic [2:0] {
    e_idle,
    e_fire,
    e_blank,
    e_wait,
    e_done
  } state_e;

  state_e                   state_r, state_n;
  logic [reps_width_p-1:0]  reps_left_r, reps_left_n;
  logic [reps_width_p-1:0]  reps_done_r, reps_done_n;
  logic [ctr_width_lp-1:0]  wait_ctr_r, wait_ctr_n;
  logic                     timeout_r, timeout_n;

  // State and counter registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= e_idle;
      reps_left_r <= '0;
      reps_done_r <= '0;
      wait_ctr_r  <= '0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_n;
      reps_left_r <= reps_left_n;
      reps_done_r <= reps_done_n;
      wait_ctr_r  <= wait_ctr_n;
      timeout_r   <= timeout_n;
    end
  end

  // Next-state and counter updates
  always_comb begin
    state_n     = state_r;
    reps_left_n = reps_left_r;
    reps_done_n = reps_done_r;
    wait_ctr_n  = wait_ctr_r;
    timeout_n   = timeout_r;

    case (state_r)
      e_idle: begin
        if (v_i) begin
          reps_left_n = reps_i;
          reps_done_n = '0;
          timeout_n   = 1'b0;
          state_n     = (reps_i == '0) ? e_done : e_fire;
        end
      end
      e_fire: begin
        wait_ctr_n = '0;
        state_n    = e_blank;
      end
      // The timer's ready is still stale here, so it is deliberately not looked at.
      e_blank: begin
        wait_ctr_n = wait_ctr_r + ctr_width_lp'(1);
        state_n    = e_wait;
      end
      e_wait: begin
        if (ready_r_i) begin
          reps_done_n = reps_done_r + reps_width_p'(1);
          reps_left_n = reps_left_r - reps_width_p'(1);
          state_n     = (reps_left_r == reps_width_p'(1)) ? e_done : e_fire;
        end else if (wait_ctr_r == ctr_width_lp'(timeout_p - 1)) begin
          timeout_n = 1'b1;
          state_n   = e_done;
        end else begin
          wait_ctr_n = wait_ctr_r + ctr_width_lp'(1);
        end
      end
      e_done: begin
        if (yumi_i) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  // Held low while reset is asserted, even though the state register already reads idle
  assign ready_and_o = (state_r == e_idle) & ~reset_i;
  assign activate_o  = (state_r == e_fire);
  assign v_o         = (state_r == e_done);
  assign reps_done_o = reps_done_r;
  assign timeout_o   = timeout_r;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && yumi_i) assert (v_o);
  end
`endif

endmodule

// File: tb/tb_bsg_wait_cycles_driver.sv
// Directed bench for bsg_wait_cycles_driver with a behavioural timer whose ready delay is set per test.
module tb_bsg_wait_cycles_driver;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       v_i;
  logic [7:0] reps_i;
  logic       ready_and_o;
  logic       activate_o;
  logic       ready_r_i;
  logic       v_o;
  logic [7:0] reps_done_o;
  logic       timeout_o;
  logic       yumi_i;

  int checks = 0;
  int errors = 0;

  // Timer model: ready rises dly cycles after the activate pulse (0 = never);
  // stale optionally leaves ready high during the cycle right after the pulse.
  int dly   = 0;
  bit stale = 1'b0;
  int since = 1000;

  always #5 clk_i = ~clk_i;

  bsg_wait_cycles_driver #(.reps_width_p(8), .timeout_p(64)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .reps_i      (reps_i),
    .ready_and_o (ready_and_o),
    .activate_o  (activate_o),
    .ready_r_i   (ready_r_i),
    .v_o         (v_o),
    .reps_done_o (reps_done_o),
    .timeout_o   (timeout_o),
    .yumi_i      (yumi_i)
  );

  always @(posedge clk_i) begin
    if (activate_o) since <= 1;
    else if (since < 100000) since <= since + 1;
  end

  assign ready_r_i = ((dly != 0) && (since >= dly)) || (stale && (since == 1));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one command, count pulses, wait for v_o, hold yumi low, then consume.
  task automatic run_cmd(input string tag, input int reps, input int hold,
                         output int npulse, output int first_p, output int last_p,
                         output int v_cyc, output int done_v, output int to_v);
    int n;
    int unstable;
    npulse = 0; first_p = -1; last_p = -1; v_cyc = -1; done_v = -1; to_v = -1;
    unstable = 0;
    @(negedge clk_i);
    check({tag, "_accept_rdy"}, int'(ready_and_o), 1);
    v_i = 1'b1;
    reps_i = 8'(reps);
    @(negedge clk_i);
    v_i = 1'b0;
    n = 1;
    while (v_cyc < 0 && n < 4000) begin
      if (activate_o) begin
        npulse++;
        if (first_p < 0) first_p = n;
        last_p = n;
      end
      if (v_o) v_cyc = n;
      else begin
        @(negedge clk_i);
        n++;
      end
    end
    if (v_cyc < 0) begin
      check({tag, "_v_o_bound"}, 0, 1);
      return;
    end
    done_v = int'(reps_done_o);
    to_v   = int'(timeout_o);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      if (!v_o || int'(reps_done_o) != done_v || int'(timeout_o) != to_v || activate_o)
        unstable++;
    end
    if (hold > 0) check({tag, "_hold_stable"}, unstable, 0);
    yumi_i = 1'b1;
    @(negedge clk_i);
    yumi_i = 1'b0;
    check({tag, "_idle_v_o"}, int'(v_o), 0);
    check({tag, "_idle_rdy"}, int'(ready_and_o), 1);
  endtask

  initial begin
    int np, fp, lp, vc, dv, tv;
    reset_i = 1'b1;
    v_i     = 1'b0;
    reps_i  = '0;
    yumi_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ready_and", int'(ready_and_o), 0);
    check("rst_activate",  int'(activate_o), 0);
    check("rst_v_o",       int'(v_o), 0);
    check("rst_reps_done", int'(reps_done_o), 0);
    check("rst_timeout",   int'(timeout_o), 0);
    reset_i = 1'b0;
    #1;
    check("rst_release_rdy", int'(ready_and_o), 1);

    // Single rep, ready at activate+5
    dly = 5;
    run_cmd("t1", 1, 0, np, fp, lp, vc, dv, tv);
    check("t1_pulses", np, 1);
    check("t1_first_pulse", fp, 1);
    check("t1_v_cycle", vc, 7);
    check("t1_reps_done", dv, 1);
    check("t1_timeout", tv, 0);

    // Three reps, four cycles apart
    dly = 3;
    run_cmd("t2", 3, 0, np, fp, lp, vc, dv, tv);
    check("t2_pulses", np, 3);
    check("t2_span", lp - fp, 8);
    check("t2_v_cycle", vc, 13);
    check("t2_reps_done", dv, 3);
    check("t2_timeout", tv, 0);

    // Timer never answers
    dly = 0;
    run_cmd("t3a", 2, 0, np, fp, lp, vc, dv, tv);
    check("t3a_pulses", np, 1);
    check("t3a_v_cycle", vc, 66);
    check("t3a_reps_done", dv, 0);
    check("t3a_timeout", tv, 1);

    // Ready lands exactly on the timeout cycle: success wins
    dly = 64;
    run_cmd("t3b", 2, 0, np, fp, lp, vc, dv, tv);
    check("t3b_pulses", np, 2);
    check("t3b_v_cycle", vc, 131);
    check("t3b_reps_done", dv, 2);
    check("t3b_timeout", tv, 0);

    // Ready one cycle too late
    dly = 65;
    run_cmd("t3c", 1, 0, np, fp, lp, vc, dv, tv);
    check("t3c_v_cycle", vc, 66);
    check("t3c_reps_done", dv, 0);
    check("t3c_timeout", tv, 1);

    // Zero reps
    dly = 3;
    run_cmd("t4", 0, 0, np, fp, lp, vc, dv, tv);
    check("t4_pulses", np, 0);
    check("t4_v_cycle", vc, 1);
    check("t4_reps_done", dv, 0);
    check("t4_timeout", tv, 0);

    // Reset while waiting
    dly = 0;
    @(negedge clk_i);
    v_i = 1'b1;
    reps_i = 8'd1;
    @(negedge clk_i);
    v_i = 1'b0;
    repeat (8) @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    check("t5w_activate", int'(activate_o), 0);
    check("t5w_v_o", int'(v_o), 0);
    check("t5w_ready_and", int'(ready_and_o), 0);
    reset_i = 1'b0;
    #1;
    check("t5w_release_rdy", int'(ready_and_o), 1);

    // Reset while holding a result
    dly = 3;
    @(negedge clk_i);
    v_i = 1'b1;
    reps_i = 8'd1;
    @(negedge clk_i);
    v_i = 1'b0;
    for (int n = 0; n < 20 && !v_o; n++) @(negedge clk_i);
    check("t5d_in_done", int'(v_o), 1);
    check("t5d_reps_done_pre", int'(reps_done_o), 1);
    reset_i = 1'b1;
    @(negedge clk_i);
    check("t5d_v_o", int'(v_o), 0);
    check("t5d_activate", int'(activate_o), 0);
    check("t5d_reps_done", int'(reps_done_o), 0);
    reset_i = 1'b0;
    #1;
    check("t5d_release_rdy", int'(ready_and_o), 1);

    // 32-cycle timer with stale ready after each pulse, consumer stalls 10 cycles
    dly = 32;
    stale = 1'b1;
    run_cmd("t6", 4, 10, np, fp, lp, vc, dv, tv);
    check("t6_pulses", np, 4);
    check("t6_last_pulse", lp, 100);
    check("t6_v_cycle", vc, 133);
    check("t6_reps_done", dv, 4);
    check("t6_timeout", tv, 0);
    stale = 1'b0;

    // All-ones repetition count
    dly = 3;
    run_cmd("t7", 255, 0, np, fp, lp, vc, dv, tv);
    check("t7_pulses", np, 255);
    check("t7_v_cycle", vc, 1021);
    check("t7_reps_done", dv, 255);
    check("t7_timeout", tv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
